ifu_predec_queue: RTL



---
 rtl/ifu_predec_queue.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ifu_predec_queue.sv
// ifu_predec_queue: fetch-side pre-decode queue.
// Each accepted instruction is mini-decoded for branch/jump class and
// statically predicted, with a small return-address stack for returns.
// It is then stored in a DEPTH-entry FIFO along with its PC and prediction.
// A predicted-taken enqueue raises a one-cycle registered redirect to fetch.
module ifu_predec_queue #(
    parameter int DEPTH     = 4,
    parameter int RAS_DEPTH = 2,
    parameter int PCW       = 32,
    parameter int IW        = 32,
    parameter int RFW       = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_valid,
    output logic           i_ready,
    input  logic [IW-1:0]  i_instr,
    input  logic [PCW-1:0] i_pc,
    input  logic           flush,
    output logic           o_valid,
    input  logic           o_ready,
    output logic [IW-1:0]  o_instr,
    output logic [PCW-1:0] o_pc,
    output logic           o_prdt_taken,
    output logic [PCW-1:0] o_prdt_pc,
    output logic           o_bjp,
    output logic           o_jal,
    output logic           o_jalr,
    output logic           o_bxx,
    output logic [RFW-1:0] o_jalr_rs1idx,
    output logic           o_redir_vld,
    output logic [PCW-1:0] o_redir_pc
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int RAW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int RCW = $clog2(RAS_DEPTH + 1);

    typedef struct packed {
        logic [IW-1:0]  instr;
        logic [PCW-1:0] pc;
        logic           prdt_taken;
        logic [PCW-1:0] prdt_pc;
        logic           jal;
        logic           jalr;
        logic           bxx;
    } entry_t;

    // ------------------------------------------------------------------
    // Mini-decode of the offered instruction
    // ------------------------------------------------------------------
    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [RFW-1:0] rd_idx;
    logic [RFW-1:0] rs1_idx;
    logic           dec_jal, dec_jalr, dec_bxx;
    logic [PCW-1:0] imm_b, imm_j, imm_i;
    logic [PCW-1:0] pc_plus4;

    assign opcode   = i_instr[6:0];
    assign funct3   = i_instr[14:12];
    assign rd_idx   = RFW'(i_instr[11:7]);
    assign rs1_idx  = RFW'(i_instr[19:15]);

    // The opcode compare includes instr[1:0]==2'b11, so compressed
    // encodings never decode as a branch.
    assign dec_jal  = (opcode == 7'b1101111);
    assign dec_jalr = (opcode == 7'b1100111) && (funct3 == 3'b000);
    assign dec_bxx  = (opcode == 7'b1100011);

    assign imm_b = {{(PCW-12){i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign imm_j = {{(PCW-20){i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
    assign imm_i = {{(PCW-11){i_instr[31]}}, i_instr[30:20]};
    assign pc_plus4 = i_pc + PCW'(4);

    // ------------------------------------------------------------------
    // Return-address stack: circular, wp points at the next free slot
    // ------------------------------------------------------------------
    logic [PCW-1:0] ras_mem [RAS_DEPTH];
    logic [RAW-1:0] ras_wp;
    logic [RCW-1:0] ras_cnt;
    logic [RAW-1:0] ras_wp_pop, ras_wp_nxt;
    logic [RCW-1:0] ras_cnt_pop, ras_cnt_nxt;
    logic           ras_ret, ras_hit, ras_push;
    logic [PCW-1:0] ras_top;

    function automatic logic [RAW-1:0] ras_inc(input logic [RAW-1:0] p);
        return (p == RAW'(RAS_DEPTH - 1)) ? '0 : p + RAW'(1);
    endfunction

    function automatic logic [RAW-1:0] ras_dec(input logic [RAW-1:0] p);
        return (p == '0) ? RAW'(RAS_DEPTH - 1) : p - RAW'(1);
    endfunction

    assign ras_ret  = dec_jalr && (rs1_idx == RFW'(1)) && (rd_idx != RFW'(1));
    assign ras_hit  = ras_ret && (ras_cnt != '0);
    assign ras_push = (dec_jal || dec_jalr) && (rd_idx == RFW'(1));
    assign ras_top  = ras_mem[ras_dec(ras_wp)];

    // RAS next state: pop first, then push on top of the popped stack;
    // when full, wp already points at the oldest entry so a push overwrites it.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        ras_wp_pop  = ras_wp;
        ras_cnt_pop = ras_cnt;
        if (ras_hit) begin
            ras_wp_pop  = ras_dec(ras_wp);
            ras_cnt_pop = ras_cnt - RCW'(1);
        end
        ras_wp_nxt  = ras_wp_pop;
        ras_cnt_nxt = ras_cnt_pop;
        if (ras_push) begin
            ras_wp_nxt  = ras_inc(ras_wp_pop);
            ras_cnt_nxt = (ras_cnt_pop == RCW'(RAS_DEPTH)) ? ras_cnt_pop : ras_cnt_pop + RCW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Static prediction
    // ------------------------------------------------------------------
    logic           prdt_taken;
    logic [PCW-1:0] prdt_pc;

    // Predict direction and target for the offered instruction.
    always_comb begin
        prdt_taken = 1'b0;
        prdt_pc    = pc_plus4;
        if (dec_bxx) begin
            if (imm_b[PCW-1]) begin
                prdt_taken = 1'b1;
                prdt_pc    = i_pc + imm_b;
            end
        end else if (dec_jal) begin
            prdt_taken = 1'b1;
            prdt_pc    = i_pc + imm_j;
        end else if (dec_jalr) begin
            if (rs1_idx == '0) begin
                prdt_taken = 1'b1;
                prdt_pc    = {imm_i[PCW-1:1], 1'b0};
            end else if (ras_hit) begin
                prdt_taken = 1'b1;
                prdt_pc    = ras_top;
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------
    entry_t         fifo_mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           full, enq, deq;
    logic           redir_pend;
    logic [PCW-1:0] redir_pc;
    entry_t         new_entry, head;

    assign full    = (count == CW'(DEPTH));
    assign i_ready = !full && !redir_pend && !flush;
    assign o_valid = (count != '0);
    assign enq     = i_valid && i_ready;
    assign deq     = o_valid && o_ready && !flush;

    assign new_entry = '{instr: i_instr, pc: i_pc, prdt_taken: prdt_taken, prdt_pc: prdt_pc,
                         jal: dec_jal, jalr: dec_jalr, bxx: dec_bxx};

    // RAS pointer/count update on accepted enqueue; flush empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            ras_wp  <= '0;
            ras_cnt <= '0;
        end else if (flush) begin
            ras_wp  <= '0;
            ras_cnt <= '0;
        end else if (enq) begin
            ras_wp  <= ras_wp_nxt;
            ras_cnt <= ras_cnt_nxt;
        end
    end

    // RAS storage write of the link address.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset; validity comes from the reset counters.
        if (enq && ras_push) ras_mem[ras_wp_pop] <= pc_plus4;
    end

    // Queue storage write.
    always_ff @(posedge clk) begin
        if (enq) fifo_mem[wr_ptr] <= new_entry;
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Redirect request raised by a predicted-taken enqueue, held one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redir_pend <= 1'b0;
            redir_pc   <= '0;
        end else if (flush) begin
            redir_pend <= 1'b0;
        end else begin
            redir_pend <= enq && prdt_taken;
            if (enq && prdt_taken) redir_pc <= prdt_pc;
        end
    end

    // A flush arriving in the redirect cycle suppresses the pulse.
    assign o_redir_vld = redir_pend && !flush;
    assign o_redir_pc  = redir_pc;

    // ------------------------------------------------------------------
    // Head outputs, forced to zero while the queue is empty
    // ------------------------------------------------------------------
    assign head = o_valid ? fifo_mem[rd_ptr] : '0;

    assign o_instr       = head.instr;
    assign o_pc          = head.pc;
    assign o_prdt_taken  = head.prdt_taken;
    assign o_prdt_pc     = head.prdt_pc;
    assign o_jal         = head.jal;
    assign o_jalr        = head.jalr;
    assign o_bxx         = head.bxx;
    assign o_bjp         = head.jal || head.jalr || head.bxx;
    assign o_jalr_rs1idx = head.jalr ? RFW'(head.instr[19:15]) : '0;

endmodule
